object_layer_gen: RTL and testbench
===================================

# object_layer_gen

Generates the 12-bit object-layer pixel stream consumed by the object/background mixer, using the same transparency encoding: a nibble value of 0 means "show background". Holds a double-buffered table of up to NUM_OBJ sprite instances (fruit, blade marks), hit-tests each scan pixel, fetches the sprite texel from an external synchronous ROM, and emits a pixel-aligned result. Sits between the VGA timing generator and the mixer.

## Interface
- NUM_OBJ, 4: number of object slots; index width is clog2(NUM_OBJ).
- H_BITS, 10: width of the horizontal coordinate.
- V_BITS, 10: width of the vertical coordinate.
- ID_BITS, 2: width of the sprite-image selector.
- SPR_LOG, 5: sprite side length is 2^SPR_LOG pixels (32x32).

Ports:
- clk  in  1  system pixel clock.
- rstn  in  1  asynchronous active-low reset.
- obj_wr  in  1  write strobe for the shadow object table.
- obj_idx  in  clog2(NUM_OBJ)  slot being written.
- obj_en  in  1  slot enable.
- obj_x  in  H_BITS  sprite top-left x.
- obj_y  in  V_BITS  sprite top-left y.
- obj_id  in  ID_BITS  sprite image selector.
- frame_start  in  1  one-cycle pulse at vblank start; commits the shadow table to the active table.
- pix_valid  in  1  current pix_x/pix_y is a visible pixel.
- pix_x  in  H_BITS  scan x.
- pix_y  in  V_BITS  scan y.
- rom_addr  out  ID_BITS+2*SPR_LOG  sprite ROM address {id, dy, dx}; registered.
- rom_data  in  12  ROM output, valid one cycle after rom_addr.
- datao  out  12  object pixel, 0 = transparent; registered.
- datao_valid  out  1  datao corresponds to a pixel presented two cycles earlier.

## Operation
- Reset: shadow and active tables cleared (all slots disabled, fields 0). rom_addr, datao, datao_valid and the internal pipeline registers are all 0.
- Table writes: when obj_wr is high, the slot at obj_idx in the shadow table takes {obj_en, obj_x, obj_y, obj_id}. An obj_idx >= NUM_OBJ is ignored.
- Commit: when frame_start is high, active <= shadow. If obj_wr and frame_start fire in the same cycle, the commit includes that write (the write is forwarded into active).
- Hit test (stage 0):
  - dx = pix_x - obj_x, computed at H_BITS+1 bits; dy = pix_y - obj_y, computed at V_BITS+1 bits.
  - A slot hits when it is enabled, neither difference is negative, and both dx and dy are less than 2^SPR_LOG.
  - Sprites clip naturally at the right and bottom edges. Negative positions are not representable.
- Priority: the lowest-index hitting slot wins. Only the winner is fetched, so a transparent texel in the winner shows background, not a lower-priority object.
- Stage 0 registers rom_addr = {id, dy[SPR_LOG-1:0], dx[SPR_LOG-1:0]}, hit_q = pix_valid & any_hit, and v_q = pix_valid. With no hit, rom_addr holds its previous value.
- Stage 1 delays hit and valid by one cycle to align with rom_data.
- Stage 2 registers datao = hit ? rom_data : 12'h000, and datao_valid = delayed valid.
- When pix_valid is low, datao is forced to 0.

## Timing
- Latency: pixel presented at cycle N produces datao/datao_valid at N+2. The pipeline accepts one pixel per cycle with no stalls.
- Table changes are visible only to pixels presented strictly after the frame_start cycle. The active table never changes mid-frame.
- frame_start during pix_valid is legal. Pixels already in the pipeline complete using the table that was active at their stage 0.
- rstn asserted mid-frame clears the pipeline immediately. The first valid output after release is 2 cycles after the first pix_valid.

## Structure
- Shared package: SPR_LOG, ID_BITS, the rom_addr packing function, and the object-entry struct {en, x, y, id}. The ROM and the mixer both use these.
- Sub-module obj_hit_test: one instance per slot, purely combinational, producing hit, dx and dy. A generate loop plus a priority encoder in the parent handles selection.

## Test plan
- Reset, then pixel (100,100) with pix_valid and an empty table → at +2 cycles, datao=000 and datao_valid=1.
- Write slot 1 as {en=1, x=100, y=50, id=2} with no frame_start, then pixel (110,60) → datao=000. After a frame_start pulse, the same pixel gives rom_addr={2,10,10} and datao=rom_data at +2.
- Slots 0 and 1 overlapping at (200,200), with the ROM returning 000 for slot 0's texel → datao=000 (lower index wins, no fall-through).
- Edge test on a slot with x=100: pixel x=131 hits (dx=31), x=132 misses, x=99 misses.
- obj_wr to slot 3 in the same cycle as frame_start → slot 3 is active for the very next pixel.
- Stream 16 consecutive pixels, then drop pix_valid for 1 cycle → datao_valid mirrors pix_valid delayed by 2 cycles, with no bubbles or duplicates.

Source files
------------

// File: rtl/object_layer_gen_pkg.sv
// Shared definitions for the object layer: sprite geometry, object-table entry
// layout and the sprite ROM address packing used by the ROM and the mixer.
package object_layer_gen_pkg;

  localparam int OBJ_H_BITS  = 10;
  localparam int OBJ_V_BITS  = 10;
  localparam int OBJ_ID_BITS = 2;
  localparam int OBJ_SPR_LOG = 5;
  localparam int OBJ_ROM_AW  = OBJ_ID_BITS + 2 * OBJ_SPR_LOG;

  // One sprite instance in the object table.
  typedef struct packed {
    logic                  en;
    logic [OBJ_H_BITS-1:0] x;
    logic [OBJ_V_BITS-1:0] y;
    logic [OBJ_ID_BITS-1:0] id;
  } obj_entry_t;

  // Sprite ROM address layout is {image id, row, column}.
  function automatic logic [OBJ_ROM_AW-1:0] rom_addr_pack(
    input logic [OBJ_ID_BITS-1:0] id,
    input logic [OBJ_SPR_LOG-1:0] dy,
    input logic [OBJ_SPR_LOG-1:0] dx
  );
    return {id, dy, dx};
  endfunction

endpackage

// File: rtl/object_layer_gen_hit_test.sv
// Per-slot hit test: offset of the scan pixel inside one sprite box.
module obj_hit_test #(
  parameter int H_BITS  = 10,
  parameter int V_BITS  = 10,
  parameter int SPR_LOG = 5
) (
  input  logic               en_i,
  input  logic [H_BITS-1:0]  obj_x_i,
  input  logic [V_BITS-1:0]  obj_y_i,
  input  logic [H_BITS-1:0]  pix_x_i,
  input  logic [V_BITS-1:0]  pix_y_i,
  output logic               hit_o,
  output logic [SPR_LOG-1:0] dx_o,
  output logic [SPR_LOG-1:0] dy_o
);

  logic [H_BITS:0] dx_full;
  logic [V_BITS:0] dy_full;

  // One extra bit catches negative offsets; a non-negative offset below the
  // sprite size has every bit at or above SPR_LOG clear.
  always_comb begin
    dx_full = {1'b0, pix_x_i} - {1'b0, obj_x_i};
    dy_full = {1'b0, pix_y_i} - {1'b0, obj_y_i};
    hit_o   = en_i && (dx_full[H_BITS:SPR_LOG] == '0) && (dy_full[V_BITS:SPR_LOG] == '0);
    dx_o    = dx_full[SPR_LOG-1:0];
    dy_o    = dy_full[SPR_LOG-1:0];
  end

endmodule

// File: rtl/object_layer_gen.sv
// Object-layer pixel generator: double-buffered sprite table, per-slot hit
// test, lowest-index priority, sprite ROM fetch and a 3-register pipeline
// (pixel sampled at edge k appears on datao after edge k+2).
module object_layer_gen
  import object_layer_gen_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int H_BITS  = OBJ_H_BITS,
  parameter int V_BITS  = OBJ_V_BITS,
  parameter int ID_BITS = OBJ_ID_BITS,
  parameter int SPR_LOG = OBJ_SPR_LOG,
  localparam int IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  localparam int AW     = ID_BITS + 2 * SPR_LOG
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               obj_wr,
  input  logic [IDX_W-1:0]   obj_idx,
  input  logic               obj_en,
  input  logic [H_BITS-1:0]  obj_x,
  input  logic [V_BITS-1:0]  obj_y,
  input  logic [ID_BITS-1:0] obj_id,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [H_BITS-1:0]  pix_x,
  input  logic [V_BITS-1:0]  pix_y,
  output logic [AW-1:0]      rom_addr,
  input  logic [11:0]        rom_data,
  output logic [11:0]        datao,
  output logic               datao_valid
);

  obj_entry_t [NUM_OBJ-1:0] shadow_q, shadow_d, active_q;

  logic [NUM_OBJ-1:0]              hit_a;
  logic [NUM_OBJ-1:0][SPR_LOG-1:0] dx_a, dy_a;

  logic             any_hit;
  logic [IDX_W-1:0] sel;
  logic             hit_d;

  logic [AW-1:0] rom_addr_q;
  logic [1:0]    vld_pipe_q;
  logic [1:0]    hit_pipe_q;
  logic [11:0]   datao_q;
  logic          datao_valid_q;

  // Shadow table with this cycle's write applied; also what a same-cycle
  // frame_start commits, so a write and a commit together take effect.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (obj_wr && (obj_idx == IDX_W'(i))) begin
        shadow_d[i].en = obj_en;
        shadow_d[i].x  = obj_x;
        shadow_d[i].y  = obj_y;
        shadow_d[i].id = obj_id;
      end
    end
  end

  // Shadow updates on every write; active only changes at frame_start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (frame_start) active_q <= shadow_d;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
    obj_hit_test #(
      .H_BITS (H_BITS),
      .V_BITS (V_BITS),
      .SPR_LOG(SPR_LOG)
    ) u_hit (
      .en_i   (active_q[g].en),
      .obj_x_i(active_q[g].x),
      .obj_y_i(active_q[g].y),
      .pix_x_i(pix_x),
      .pix_y_i(pix_y),
      .hit_o  (hit_a[g]),
      .dx_o   (dx_a[g]),
      .dy_o   (dy_a[g])
    );
  end

  // Lowest-index hitting slot wins; scanning downward lets it overwrite last.
  always_comb begin
    any_hit = 1'b0;
    sel     = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_a[i]) begin
        any_hit = 1'b1;
        sel     = IDX_W'(i);
      end
    end
    hit_d = pix_valid && any_hit;
  end

  // Stage 0 fetch address and stage 0/1 valid/hit delay to line up with ROM data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rom_addr_q <= '0;
      vld_pipe_q <= '0;
      hit_pipe_q <= '0;
    end else begin
      if (hit_d) rom_addr_q <= rom_addr_pack(active_q[sel].id, dy_a[sel], dx_a[sel]);
      vld_pipe_q <= {vld_pipe_q[0], pix_valid};
      hit_pipe_q <= {hit_pipe_q[0], hit_d};
    end
  end

  // Stage 2: take the texel only for a hit, otherwise transparent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      datao_q       <= '0;
      datao_valid_q <= 1'b0;
    end else begin
      datao_q       <= hit_pipe_q[1] ? rom_data : 12'h000;
      datao_valid_q <= vld_pipe_q[1];
    end
  end

  assign rom_addr    = rom_addr_q;
  assign datao       = datao_q;
  assign datao_valid = datao_valid_q;

endmodule

// File: tb/tb_object_layer_gen.sv
// Bench for object_layer_gen: directed scenarios plus random traffic, checked
// every cycle against a slot-table model and a synchronous ROM model.
module tb_object_layer_gen;

  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        obj_wr = 1'b0;
  logic [1:0]  obj_idx = '0;
  logic        obj_en = 1'b0;
  logic [9:0]  obj_x = '0;
  logic [9:0]  obj_y = '0;
  logic [1:0]  obj_id = '0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;
  logic [AW-1:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [11:0] datao;
  logic        datao_valid;

  object_layer_gen dut (
    .clk(clk), .rstn(rstn), .obj_wr(obj_wr), .obj_idx(obj_idx), .obj_en(obj_en),
    .obj_x(obj_x), .obj_y(obj_y), .obj_id(obj_id), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .rom_addr(rom_addr),
    .rom_data(rom_data), .datao(datao), .datao_valid(datao_valid)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: texels whose low column nibble is 0 are transparent.
  function automatic logic [11:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {20'd0, a} * 32'd40503 + 32'd4660;
    return (a[3:0] == 4'd0) ? 12'h000 : {h[15:5], 1'b1};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  typedef struct { int en; int x; int y; int id; } mobj_t;
  mobj_t m_sh[4];
  mobj_t m_ac[4];
  int hv[3];
  int hd[3];
  int exp_addr;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = '{0, 0, 0, 0};
      m_ac[i] = '{0, 0, 0, 0};
    end
    for (int i = 0; i < 3; i++) begin hv[i] = 0; hd[i] = 0; end
    exp_addr = 0;
  endtask

  // One clock: predict this pixel, update the tables, then check outputs.
  task automatic tick();
    int cv, cd, found, dx, dy;
    @(posedge clk);
    cv = int'(pix_valid);
    cd = 0;
    found = 0;
    if (pix_valid) begin
      for (int s = 0; s < 4; s++) begin
        dx = int'(pix_x) - m_ac[s].x;
        dy = int'(pix_y) - m_ac[s].y;
        if (found == 0 && m_ac[s].en != 0 && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
          found = 1;
          exp_addr = m_ac[s].id * 1024 + dy * 32 + dx;
          cd = int'(rom_fn(AW'(exp_addr)));
        end
      end
    end
    hv[2] = hv[1]; hd[2] = hd[1];
    hv[1] = hv[0]; hd[1] = hd[0];
    hv[0] = cv;    hd[0] = cd;
    if (obj_wr) m_sh[obj_idx] = '{int'(obj_en), int'(obj_x), int'(obj_y), int'(obj_id)};
    if (frame_start) m_ac = m_sh;
    #1;
    chk("datao_valid", 32'(datao_valid), 32'(hv[2]));
    chk("datao", 32'(datao), 32'(hd[2]));
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    obj_wr = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input bit v);
    pix_valid = v; pix_x = 10'(x); pix_y = 10'(y);
    tick();
  endtask

  task automatic wr(input int idx, input bit en, input int x, input int y, input int id, input bit fs);
    obj_wr = 1'b1; obj_idx = 2'(idx); obj_en = en;
    obj_x = 10'(x); obj_y = 10'(y); obj_id = 2'(id);
    frame_start = fs;
    pix_valid = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_datao", 32'(datao), 32'd0);
    chk("reset_datao_valid", 32'(datao_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Empty table: transparent but valid
    pix(100, 100, 1);
    pix(0, 0, 0);
    pix(0, 0, 0);
    chk("empty_valid", 32'(datao_valid), 32'd1);
    chk("empty_datao", 32'(datao), 32'd0);

    // Shadow write is invisible until frame_start
    wr(1, 1, 100, 50, 2, 0);
    pix(110, 60, 1);
    pix(0, 0, 0);
    pix(0, 0, 0);
    chk("shadow_hidden", 32'(datao), 32'd0);
    frame_start = 1'b1; pix(0, 0, 0);
    pix(110, 60, 1);
    chk("commit_addr", 32'(rom_addr), 32'd2378);
    pix(0, 0, 0);
    pix(0, 0, 0);
    chk("commit_datao", 32'(datao), 32'(rom_fn(12'd2378)));

    // Overlap: slot 0 wins with a transparent texel, no fall-through
    wr(0, 1, 200, 200, 1, 0);
    wr(1, 1, 195, 195, 2, 1);
    pix(200, 200, 1);
    chk("overlap_addr", 32'(rom_addr), 32'd1024);
    pix(0, 0, 0);
    pix(0, 0, 0);
    chk("overlap_datao", 32'(datao), 32'd0);
    chk("overlap_valid", 32'(datao_valid), 32'd1);

    // Right/left edge of a sprite at x=100
    wr(0, 0, 0, 0, 0, 0);
    wr(1, 0, 0, 0, 0, 0);
    wr(2, 1, 100, 300, 3, 1);
    pix(131, 305, 1);
    chk("edge_addr", 32'(rom_addr), 32'(3 * 1024 + 5 * 32 + 31));
    pix(132, 305, 1);
    pix(99, 305, 1);
    chk("edge_hit_131", 32'(datao), 32'(rom_fn(12'(3 * 1024 + 5 * 32 + 31))));
    pix(0, 0, 0);
    chk("edge_miss_132", 32'(datao), 32'd0);
    pix(0, 0, 0);
    chk("edge_miss_99", 32'(datao), 32'd0);

    // Write and commit in the same cycle: visible to the next pixel only
    obj_wr = 1'b1; obj_idx = 2'd3; obj_en = 1'b1; obj_x = 10'd500; obj_y = 10'd400;
    obj_id = 2'd0; frame_start = 1'b1;
    pix(510, 410, 1);
    pix(510, 410, 1);
    chk("fwd_addr", 32'(rom_addr), 32'd330);
    pix(0, 0, 0);
    chk("fwd_old_miss", 32'(datao), 32'd0);
    pix(0, 0, 0);
    chk("fwd_new_hit", 32'(datao), 32'(rom_fn(12'd330)));

    // Streaming with a one-cycle gap
    for (int i = 0; i < 16; i++) pix(495 + i, 395 + i, 1);
    pix(0, 0, 0);
    for (int i = 0; i < 4; i++) pix(500 + i, 400, 1);
    pix(0, 0, 0);
    pix(0, 0, 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        obj_wr = 1'b1; obj_idx = 2'($urandom_range(0, 3));
        obj_en = ($urandom_range(0, 9) != 0);
        obj_x = 10'($urandom_range(0, 150)); obj_y = 10'($urandom_range(0, 150));
        obj_id = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
          obj_x = 10'($urandom_range(990, 1023)); obj_y = 10'($urandom_range(990, 1023));
        end
      end
      if ($urandom_range(0, 19) == 0) frame_start = 1'b1;
      if ($urandom_range(0, 7) == 0)
        pix($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3) != 0);
      else
        pix($urandom_range(0, 200), $urandom_range(0, 200), $urandom_range(0, 5) != 0);
    end

    // Asynchronous reset mid-frame
    pix(20, 20, 1);
    pix(21, 20, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_datao", 32'(datao), 32'd0);
    chk("midrst_valid", 32'(datao_valid), 32'd0);
    chk("midrst_addr", 32'(rom_addr), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pix(30, 30, 1);
    chk("post_rst_valid0", 32'(datao_valid), 32'd0);
    pix(0, 0, 0);
    chk("post_rst_valid1", 32'(datao_valid), 32'd0);
    pix(0, 0, 0);
    chk("post_rst_valid2", 32'(datao_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
